fbuf_scanout: RTL and testbench



---
 rtl/gpu_video_pkg.sv | 48 ++++
 rtl/video_timing_gen.sv | 66 ++++++
 rtl/fbuf_scanout.sv | 173 +++++++++++++++++
 tb/tb_fbuf_scanout.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_video_pkg.sv
// Shared 640x480@60 video timing constants, RGB332 expansion
// and test-pattern colours for the GPU video path.
package gpu_video_pkg;

    localparam int VID_H_ACTIVE = 640;
    localparam int VID_H_FP     = 16;
    localparam int VID_H_SYNC   = 96;
    localparam int VID_H_BP     = 48;
    localparam int VID_H_TOTAL  = 800;

    localparam int VID_V_ACTIVE = 480;
    localparam int VID_V_FP     = 10;
    localparam int VID_V_SYNC   = 2;
    localparam int VID_V_BP     = 33;
    localparam int VID_V_TOTAL  = 525;

    localparam logic [23:0] TP_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] TP_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] TP_CYAN    = 24'h00FFFF;
    localparam logic [23:0] TP_GREEN   = 24'h00FF00;
    localparam logic [23:0] TP_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] TP_RED     = 24'hFF0000;
    localparam logic [23:0] TP_BLUE    = 24'h0000FF;
    localparam logic [23:0] TP_BLACK   = 24'h000000;

    // Index 0 is the leftmost bar.
    localparam logic [7:0][23:0] TP_BARS = {
        TP_BLACK, TP_BLUE, TP_RED, TP_MAGENTA,
        TP_GREEN, TP_CYAN, TP_YELLOW, TP_WHITE
    };

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic fs;
        logic vb;
    } vid_tap_t;

    function automatic logic [23:0] rgb332_to_rgb888(
        input logic [7:0] p
    );
        return {p[7:5], p[7:5], p[7:6],
                p[4:2], p[4:2], p[4:3],
                {4{p[1:0]}}};
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters and raw (undelayed,
// active-high) visible, sync, vblank and frame-boundary flags.
module video_timing_gen
    import gpu_video_pkg::*;
#(
    parameter int H_ACTIVE = VID_H_ACTIVE,
    parameter int H_FP     = VID_H_FP,
    parameter int H_SYNC   = VID_H_SYNC,
    parameter int H_BP     = VID_H_BP,
    parameter int V_ACTIVE = VID_V_ACTIVE,
    parameter int V_FP     = VID_V_FP,
    parameter int V_SYNC   = VID_V_SYNC,
    parameter int V_BP     = VID_V_BP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_visible,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_vblank,
    output logic o_frame_start,
    output logic o_frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_run) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    assign o_visible = (r_h_cnt < HW'(H_ACTIVE)) &&
                       (r_v_cnt < VW'(V_ACTIVE));

    assign o_hsync = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                     (r_h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));

    assign o_vsync = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                     (r_v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

    assign o_vblank      = (r_v_cnt >= VW'(V_ACTIVE));
    assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_frame_end   = w_h_last && w_v_last;

endmodule

// File: rtl/fbuf_scanout.sv
// Framebuffer scan-out: address generation, BRAM-latency pipeline,
// RGB332 expansion. Optional FBUF_SCANOUT_TEST_PATTERN_EN colour bars.
module fbuf_scanout
    import gpu_video_pkg::*;
#(
    parameter int   H_ACTIVE        = VID_H_ACTIVE,
    parameter int   H_FP            = VID_H_FP,
    parameter int   H_SYNC          = VID_H_SYNC,
    parameter int   H_BP            = VID_H_BP,
    parameter int   V_ACTIVE        = VID_V_ACTIVE,
    parameter int   V_FP            = VID_V_FP,
    parameter int   V_SYNC          = VID_V_SYNC,
    parameter int   V_BP            = VID_V_BP,
    parameter logic SYNC_POL        = 1'b0,
    parameter int   FBUF_ADDR_WIDTH = 19,
    parameter int   FBUF_DATA_WIDTH = 8,
    parameter int   FBUF_RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fbuf_rst_busy,
`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
    input  logic                       test_pattern_sel,
`endif
    output logic                       fbuf_en_rd,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] fbuf_rdata,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       de,
    output logic [23:0]                rgb,
    output logic                       frame_start,
    output logic                       vblank
);

    localparam int L = FBUF_RD_LATENCY;

    logic w_visible, w_hsync, w_vsync, w_vblank;
    logic w_frame_start, w_frame_end, w_vis_run;
    logic r_run;
    logic [FBUF_ADDR_WIDTH-1:0] r_rd_addr;
    vid_tap_t r_pipe [L];
    vid_tap_t w_tap, w_tail;
    logic [23:0] w_pix;
    logic r_hsync, r_vsync, r_de, r_fs, r_vb;
    logic [23:0] r_rgb;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
        .H_SYNC(H_SYNC),     .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
        .V_SYNC(V_SYNC),     .V_BP(V_BP)
    ) u_timing (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_run        (r_run),
        .o_visible    (w_visible),
        .o_hsync      (w_hsync),
        .o_vsync      (w_vsync),
        .o_vblank     (w_vblank),
        .o_frame_start(w_frame_start),
        .o_frame_end  (w_frame_end)
    );

    // Holds the counters at (0,0) for the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    assign w_vis_run  = w_visible & r_run;
    assign fbuf_en_rd = w_vis_run;
    assign fbuf_addr  = r_rd_addr;

    always_ff @(posedge clk) begin
        if (!rst_n)                  r_rd_addr <= '0;
        else if (w_frame_end)        r_rd_addr <= '0;
        else if (w_vis_run)          r_rd_addr <= r_rd_addr + 1'b1;
    end

    always_comb begin
        w_tap     = '0;
        w_tap.vis = w_vis_run;
        w_tap.hs  = w_hsync;
        w_tap.vs  = w_vsync;
        w_tap.fs  = w_frame_start & r_run;
        w_tap.vb  = w_vblank;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_tap;
            for (int i = 1; i < L; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_tail = r_pipe[L-1];

`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int BAR_CW = $clog2(BAR_W + 1);

    logic [BAR_CW-1:0] r_bar_px;
    logic [2:0]        r_bar;
    logic [2:0]        r_bar_pipe [L];

    // Bar position restarts whenever the raster leaves the visible area.
    always_ff @(posedge clk) begin
        if (!rst_n || !w_vis_run) begin
            r_bar_px <= '0;
            r_bar    <= '0;
        end else if (r_bar_px == BAR_CW'(BAR_W - 1)) begin
            r_bar_px <= '0;
            r_bar    <= r_bar + 1'b1;
        end else begin
            r_bar_px <= r_bar_px + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) r_bar_pipe[i] <= '0;
        end else begin
            r_bar_pipe[0] <= r_bar;
            for (int i = 1; i < L; i++)
                r_bar_pipe[i] <= r_bar_pipe[i-1];
        end
    end
`endif

    always_comb begin
        w_pix = '0;
        if (w_tail.vis) begin
`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
            if (test_pattern_sel)
                w_pix = TP_BARS[r_bar_pipe[L-1]];
            else if (!fbuf_rst_busy)
                w_pix = rgb332_to_rgb888(fbuf_rdata);
`else
            if (!fbuf_rst_busy)
                w_pix = rgb332_to_rgb888(fbuf_rdata);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_de    <= 1'b0;
            r_fs    <= 1'b0;
            r_vb    <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_tail.hs ? SYNC_POL : ~SYNC_POL;
            r_vsync <= w_tail.vs ? SYNC_POL : ~SYNC_POL;
            r_de    <= w_tail.vis;
            r_fs    <= w_tail.fs;
            r_vb    <= w_tail.vb;
            r_rgb   <= w_pix;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign frame_start = r_fs;
    assign vblank      = r_vb;
    assign rgb         = r_rgb;

endmodule

// File: tb/tb_fbuf_scanout.sv
// Bench for fbuf_scanout on a shrunken raster with a BRAM model
// and an arithmetic reference of the expected pin stream.
module tb_fbuf_scanout;

    localparam int HA = 40, HF = 4, HS = 6, HB = 5;
    localparam int VA = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy = 1'b0;
    logic        tp = 1'b0;
    logic        fbuf_en_rd;
    logic [18:0] fbuf_addr;
    logic [7:0]  rdata = 8'h00;
    logic        hsync, vsync, de, frame_start, vblank;
    logic [23:0] rgb;

    int checks = 0;
    int errors = 0;
    int seed;
    logic busy_hist = 1'b0;
    logic tp_hist = 1'b0;

    always #5 clk = ~clk;

    fbuf_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .FBUF_ADDR_WIDTH(19),
        .FBUF_DATA_WIDTH(8), .FBUF_RD_LATENCY(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fbuf_rst_busy(busy),
`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
        .test_pattern_sel(tp),
`endif
        .fbuf_en_rd   (fbuf_en_rd),
        .fbuf_addr    (fbuf_addr),
        .fbuf_rdata   (rdata),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .rgb          (rgb),
        .frame_start  (frame_start),
        .vblank       (vblank)
    );

    function automatic logic [7:0] mem_f(input int a);
        int t;
        if (a == 5) return 8'hE0;
        if (a == 6) return 8'h1C;
        if (a == 7) return 8'h03;
        t = (a * 73 + seed) ^ (a >> 3);
        return t[7:0];
    endfunction

    always @(posedge clk)
        if (fbuf_en_rd) rdata <= mem_f(int'(fbuf_addr));

    function automatic logic [23:0] expand(input logic [7:0] p);
        int r3, g3, b2, r8, g8, b8;
        r3 = int'(p[7:5]);
        g3 = int'(p[4:2]);
        b2 = int'(p[1:0]);
        r8 = r3 * 36 + r3 / 2;
        g8 = g3 * 36 + g3 / 2;
        b8 = b2 * 85;
        return {r8[7:0], g8[7:0], b8[7:0]};
    endfunction

    function automatic logic [23:0] bar_col(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_de", 32'(de), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_vblank", 32'(vblank), 32'd0);
        check("rst_en_rd", 32'(fbuf_en_rd), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
    endtask

    task automatic check_cycle(input int j);
        int s, h, v, h0, v0;
        logic e_en, e_vis, e_hs, e_vs, e_fs, e_vb;
        logic [23:0] e_rgb;
        h0 = j % HT;
        v0 = (j / HT) % VT;
        e_en = (h0 < HA) && (v0 < VA);
        check("en_rd", 32'(fbuf_en_rd), 32'(e_en));
        if (e_en) check("addr", 32'(fbuf_addr), 32'(v0 * HA + h0));
        if (e_en && h0 == HA - 1 && v0 == VA - 1)
            check("last_addr", 32'(fbuf_addr), 32'(HA * VA - 1));
        s = j - 2;
        e_vis = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_vb = 0;
        e_rgb = '0;
        if (s >= 0) begin
            h = s % HT;
            v = (s / HT) % VT;
            e_vis = (h < HA) && (v < VA);
            e_hs = (h >= HA + HF) && (h < HA + HF + HS);
            e_vs = (v >= VA + VF) && (v < VA + VF + VS);
            e_fs = (h == 0) && (v == 0);
            e_vb = (v >= VA);
            if (e_vis) begin
                if (tp_hist) e_rgb = bar_col(h / (HA / 8));
                else if (!busy_hist) e_rgb = expand(mem_f(v * HA + h));
            end
        end
        check("de", 32'(de), 32'(e_vis));
        check("hsync", 32'(hsync), 32'(!e_hs));
        check("vsync", 32'(vsync), 32'(!e_vs));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("vblank", 32'(vblank), 32'(e_vb));
        check("rgb", 32'(rgb), 32'(e_rgb));
    endtask

    task automatic run(input int n, input bit directed);
        int de_rise, hs_rise, last_fs, sn;
        int pend [3];
        logic [23:0] pexp [3];
        bit de_seen, prev_de, prev_hs, hs_act;
        de_rise = 0; hs_rise = 0; last_fs = -1;
        de_seen = 0; prev_de = 0; prev_hs = 0;
        pexp[0] = 24'hFF0000;
        pexp[1] = 24'h00FF00;
        pexp[2] = 24'h0000FF;
        for (int i = 0; i < 3; i++) pend[i] = -1;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (j == 0) begin
                check("first_en", 32'(fbuf_en_rd), 32'd1);
                check("first_addr", 32'(fbuf_addr), 32'd0);
            end
            check_cycle(j);
            for (int i = 0; i < 3; i++)
                if (pend[i] == j) begin
                    if (!busy_hist && !tp_hist)
                        check("px_known", 32'(rgb), 32'(pexp[i]));
                    pend[i] = -1;
                end
            if (fbuf_en_rd && fbuf_addr >= 5 && fbuf_addr <= 7)
                pend[int'(fbuf_addr) - 5] = j + 2;
            if (busy_hist && !tp_hist && de)
                check("busy_blank", 32'(rgb), 32'd0);
            if (de && !prev_de) begin
                de_rise = j;
                de_seen = 1;
            end
            if (!de && prev_de)
                check("de_width", 32'(j - de_rise), 32'(HA));
            hs_act = !hsync;
            if (hs_act && !prev_hs) begin
                hs_rise = j;
                if (de_seen)
                    check("hs_offset", 32'(j - de_rise), 32'(HA + HF));
                de_seen = 0;
            end
            if (!hs_act && prev_hs)
                check("hs_width", 32'(j - hs_rise), 32'(HS));
            if (frame_start) begin
                if (last_fs >= 0)
                    check("fs_period", 32'(j - last_fs), 32'(FT));
                last_fs = j;
            end
            prev_de = de;
            prev_hs = hs_act;
            sn = j - 1;
            if (directed && j < FT + 1) begin
                busy = (sn >= 0) && ((sn / HT) == 2) &&
                       ((sn % HT) >= 10) && ((sn % HT) < 20);
                tp = 1'b0;
            end else if (directed && j < 2 * FT + 1) begin
`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
                tp = 1'b1;
                busy = ($urandom % 3) == 0;
`else
                tp = 1'b0;
                busy = 1'b0;
`endif
            end else begin
                busy = ($urandom % 5) == 0;
`ifdef FBUF_SCANOUT_TEST_PATTERN_EN
                tp = ($urandom % 4) == 0;
`else
                tp = 1'b0;
`endif
            end
            busy_hist = busy;
            tp_hist = tp;
        end
    endtask

    initial begin
        seed = int'($urandom);
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_reset();
        end
        rst_n = 1'b1;
        run(3 * FT + 2 * HT + 17, 1'b1);
        rst_n = 1'b0;
        busy = 1'b0;
        tp = 1'b0;
        busy_hist = 1'b0;
        tp_hist = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset();
        end
        rst_n = 1'b1;
        run(FT + 3 * HT, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
